// File: rtl/store_align_unit_pkg.sv
// Shared store/load definitions: op one-hot bit indices, bus FSM states, size codes.
// Also provides the alignment predicate used by the optional address-error check.
package store_align_unit_pkg;

  localparam int OP_W   = 5;
  localparam int OP_SB  = 0;
  localparam int OP_SH  = 1;
  localparam int OP_SW  = 2;
  localparam int OP_SWL = 3;
  localparam int OP_SWR = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // SWL/SWR are unaligned by definition; only SH and SW can fault.
  function automatic logic is_misaligned(input logic [OP_W-1:0] op, input logic [1:0] a);
    return (op[OP_SH] & a[0]) | (op[OP_SW] & (a != 2'b00));
  endfunction

endpackage

// File: rtl/store_align_unit_if.sv
// Pipeline-side store request and SRAM-like data-bus write signals for store_align_unit.
// slave: the store unit; master: the pipeline/bus environment around it.
interface store_align_unit_if import store_align_unit_pkg::*; #(
  parameter int ADDR_W = 32
) ();

  logic              in_valid;
  logic              in_ready;
  logic [OP_W-1:0]   in_op;
  logic [ADDR_W-1:0] in_addr;
  logic [31:0]       in_rt;
  logic              flush;

  logic              data_req;
  logic              data_wr;
  logic [1:0]        data_size;
  logic [ADDR_W-1:0] data_addr;
  logic [3:0]        data_wstrb;
  logic [31:0]       data_wdata;
  logic              data_addr_ok;
  logic              data_data_ok;

  logic              done;
  logic              ades;

  modport slave (
    input  in_valid, in_op, in_addr, in_rt, flush, data_addr_ok, data_data_ok,
    output in_ready, data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
           done, ades
  );

  modport master (
    output in_valid, in_op, in_addr, in_rt, flush, data_addr_ok, data_data_ok,
    input  in_ready, data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
           done, ades
  );

endinterface

// File: rtl/store_align_unit_lane_gen.sv
// store_lane_gen: combinational byte strobe, lane-shifted write data and bus size
// for SB/SH/SW/SWL/SWR on a little-endian 32-bit bus.
module store_lane_gen import store_align_unit_pkg::*; (
  input  logic [OP_W-1:0] op,
  input  logic [1:0]      a,
  input  logic [31:0]     rt,
  output logic [3:0]      wstrb,
  output logic [31:0]     wdata,
  output logic [1:0]      size
);

  // Lane selection per store flavour; an empty op produces an all-zero strobe.
  always_comb begin
    wstrb = 4'b0000;
    wdata = 32'h0000_0000;
    size  = SIZE_WORD;
    if (op[OP_SB]) begin
      wstrb = 4'b0001 << a;
      wdata = {4{rt[7:0]}};
      size  = SIZE_BYTE;
    end else if (op[OP_SH]) begin
      wstrb = a[1] ? 4'b1100 : 4'b0011;
      wdata = {2{rt[15:0]}};
      size  = SIZE_HALF;
    end else if (op[OP_SW]) begin
      wstrb = 4'b1111;
      wdata = rt;
    end else if (op[OP_SWL]) begin
      case (a)
        2'b00:   begin wstrb = 4'b0001; wdata = {24'h00_0000, rt[31:24]}; end
        2'b01:   begin wstrb = 4'b0011; wdata = {16'h0000, rt[31:16]}; end
        2'b10:   begin wstrb = 4'b0111; wdata = {8'h00, rt[31:8]}; end
        2'b11:   begin wstrb = 4'b1111; wdata = rt; end
        default: begin wstrb = 4'b0000; wdata = 32'h0000_0000; end
      endcase
    end else if (op[OP_SWR]) begin
      case (a)
        2'b00:   begin wstrb = 4'b1111; wdata = rt; end
        2'b01:   begin wstrb = 4'b1110; wdata = {rt[23:0], 8'h00}; end
        2'b10:   begin wstrb = 4'b1100; wdata = {rt[15:0], 16'h0000}; end
        2'b11:   begin wstrb = 4'b1000; wdata = {rt[7:0], 24'h00_0000}; end
        default: begin wstrb = 4'b0000; wdata = 32'h0000_0000; end
      endcase
    end else begin
      wstrb = 4'b0000;
      wdata = 32'h0000_0000;
      size  = SIZE_WORD;
    end
  end

endmodule

// File: rtl/store_align_unit.sv
// MEM-stage store request generator: captures one store, issues a single-outstanding
// bus write and pulses done on retirement. Optional STORE_ALIGN_CHECK_EN raises ades.
module store_align_unit import store_align_unit_pkg::*; #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  store_align_unit_if.slave bus
);

  logic [3:0]        lane_wstrb_s;
  logic [31:0]       lane_wdata_s;
  logic [1:0]        lane_size_s;
  logic [ADDR_W-1:0] req_addr_s;
  logic              accept_s;
  logic              misalign_s;

  state_e            state_r;
  logic              in_ready_r;
  logic              data_req_r;
  logic [1:0]        data_size_r;
  logic [ADDR_W-1:0] data_addr_r;
  logic [3:0]        data_wstrb_r;
  logic [DATA_W-1:0] data_wdata_r;
  logic              done_r;
  logic              ades_r;

  store_lane_gen u_lane_gen (
    .op    (bus.in_op),
    .a     (bus.in_addr[1:0]),
    .rt    (bus.in_rt),
    .wstrb (lane_wstrb_s),
    .wdata (lane_wdata_s),
    .size  (lane_size_s)
  );

  assign accept_s   = bus.in_valid & in_ready_r & (|bus.in_op);
  // Byte/half keep the exact address; word-sized accesses go out word-aligned.
  assign req_addr_s = (bus.in_op[OP_SB] | bus.in_op[OP_SH]) ? bus.in_addr
                                                             : {bus.in_addr[ADDR_W-1:2], 2'b00};

`ifdef STORE_ALIGN_CHECK_EN
  assign misalign_s = is_misaligned(bus.in_op, bus.in_addr[1:0]);
`else
  assign misalign_s = 1'b0;
`endif

  // Bus FSM with registered request, capture and completion outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      in_ready_r   <= 1'b1;
      data_req_r   <= 1'b0;
      data_size_r  <= 2'd0;
      data_addr_r  <= '0;
      data_wstrb_r <= 4'b0000;
      data_wdata_r <= '0;
      done_r       <= 1'b0;
      ades_r       <= 1'b0;
    end else begin
      done_r <= 1'b0;
      ades_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (accept_s && misalign_s) begin
            // Faulting store never reaches the bus; a concurrent flush kills the report.
            done_r <= ~bus.flush;
            ades_r <= ~bus.flush;
          end else if (accept_s) begin
            state_r      <= ST_REQ;
            in_ready_r   <= 1'b0;
            data_req_r   <= 1'b1;
            data_size_r  <= lane_size_s;
            data_addr_r  <= req_addr_s;
            data_wstrb_r <= lane_wstrb_s;
            data_wdata_r <= lane_wdata_s;
          end
        end
        ST_REQ: begin
          if (bus.data_addr_ok) begin
            data_req_r <= 1'b0;
            state_r    <= bus.flush ? ST_DRAIN : ST_WAIT;
          end else if (bus.flush) begin
            data_req_r <= 1'b0;
            in_ready_r <= 1'b1;
            state_r    <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (bus.data_data_ok) begin
            done_r     <= ~bus.flush;
            in_ready_r <= 1'b1;
            state_r    <= ST_IDLE;
          end else if (bus.flush) begin
            state_r <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (bus.data_data_ok) begin
            in_ready_r <= 1'b1;
            state_r    <= ST_IDLE;
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          in_ready_r <= 1'b1;
          data_req_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready   = in_ready_r;
  assign bus.data_req   = data_req_r;
  assign bus.data_wr    = data_req_r;
  assign bus.data_size  = data_size_r;
  assign bus.data_addr  = data_addr_r;
  assign bus.data_wstrb = data_wstrb_r;
  assign bus.data_wdata = data_wdata_r;
  assign bus.done       = done_r;
  assign bus.ades       = ades_r;

endmodule

// File: doc/store_align_unit.md
Name: store_align_unit

Overview:
MEM-side store request generator for the 5-stage MIPS pipeline. It is the write-direction counterpart of the WB load-data extractor.
- Takes one store instruction (SB/SH/SW/SWL/SWR) from EXE.
- Forms the byte strobe and lane-shifted write data.
- Drives a single-outstanding SRAM-like data-bus write (req/addr_ok/data_ok) and reports completion to the pipeline.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data bus width; only 32 supported

Ports:
clk  in  1  clock
reset  in  1  reset; asynchronous, active-high
in_valid  in  1  EXE presents a store
in_ready  out  1  unit can accept a store (state IDLE)
in_op  in  5  one-hot {SWR,SWL,SW,SH,SB}
in_addr  in  ADDR_W  effective address
in_rt  in  32  rt register value
flush  in  1  pipeline flush (exception/eret)
data_req  out  1  bus request
data_wr  out  1  write flag, 1 whenever data_req=1
data_size  out  2  0=byte,1=half,2=word
data_addr  out  ADDR_W  bus address
data_wstrb  out  4  byte write strobe
data_wdata  out  32  lane-aligned write data
data_addr_ok  in  1  bus accepted address/data
data_data_ok  in  1  bus write completed
done  out  1  1-cycle pulse: store retired
ades  out  1  with done: address-error store (optional feature)

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset: state=IDLE; all bus outputs, done and ades = 0; in_ready=1; internal registers = 0.
- Handshake: a store is accepted on in_valid & in_ready. Only one op bit is high at a time; an all-zero in_op is ignored.
- Capture: the store is registered at acceptance. data_* outputs are driven from registers only, with no combinational path from in_*.
- Strobe/data, a=in_addr[1:0], little-endian:
  - SB: wstrb=4'b0001<<a; wdata={4{rt[7:0]}}; size 0; addr unmodified.
  - SH: wstrb=a[1]?1100:0011; wdata={2{rt[15:0]}}; size 1; addr unmodified.
  - SW: wstrb=1111; wdata=rt; size 2.
  - SWL: a=00 → 0001, {24'b0,rt[31:24]}; a=01 → 0011, {16'b0,rt[31:16]}; a=10 → 0111, {8'b0,rt[31:8]}; a=11 → 1111, rt.
  - SWR: a=00 → 1111, rt; a=01 → 1110, {rt[23:0],8'b0}; a=10 → 1100, {rt[15:0],16'b0}; a=11 → 1000, {rt[7:0],24'b0}.
  - SW/SWL/SWR: size 2, data_addr={addr[31:2],2'b00}.
- FSM:
  - IDLE: on accept → REQ.
  - REQ: data_req=1, outputs held stable. addr_ok → WAIT. flush & !addr_ok → IDLE, request dropped, no done. flush & addr_ok → DRAIN.
  - WAIT: data_req=0. data_ok → IDLE with done=1. flush & !data_ok → DRAIN. flush & data_ok → IDLE, done suppressed.
  - DRAIN: data_req=0; waits for data_ok → IDLE, no done.
- Latency:
  - accept → data_req next cycle;
  - min accept → done = 3 cycles (addr_ok in 1st REQ cycle, data_ok in 1st WAIT cycle).
- data_ok in the same cycle as addr_ok is not permitted by the bus and is not handled.
- Reset mid-transaction returns to IDLE immediately; the bus side is reset by the same signal.

Optional Feature:
STORE_ALIGN_CHECK_EN:
- Defined: at acceptance, SH with addr[0]=1 or SW with addr[1:0]≠00 issues no bus request. The next cycle pulses done=1, ades=1, and the FSM stays IDLE. A flush in that cycle suppresses the pulse.
- Undefined: no check; ades tied 0. Misaligned SH uses wstrb per a[1]; misaligned SW uses addr forced to {addr[31:2],2'b00}.

Decomposition:
- Shared package: store op one-hot bit indices, FSM state encodings (IDLE/REQ/WAIT/DRAIN), and size constants (byte/half/word). These are shared with the load-extract logic.
- One natural sub-module: store_lane_gen (combinational op+a+rt → wstrb/wdata/size). It is instantiated once before the capture registers.

Test Plan:
- SB addr=0x1003, rt=0x123456AB, addr_ok/data_ok immediate → wstrb=1000, wdata=0xABABABAB, size 0; done 3 cycles after accept.
- SWL addr=0x2001, rt=0xAABBCCDD → wstrb=0011, wdata=0x0000AABB, addr=0x2000. SWR addr=0x2002, same rt → wstrb=1100, wdata=0xCCDD0000.
- addr_ok held low 5 cycles → data_req and all data_* stable throughout; in_ready=0; a second in_valid is not accepted.
- flush in REQ before addr_ok → data_req drops next cycle, no done. flush in WAIT, data_ok 2 cycles later → DRAIN then IDLE, no done.
- With STORE_ALIGN_CHECK_EN: SW addr=0x3002 → no data_req; done=1, ades=1 one cycle after accept. Without the macro: req to 0x3000, wstrb=1111.
- Reset asserted asynchronously while in WAIT → data_req/done=0 immediately; in_ready=1 after release.
